// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requesters. Each cycle at
//   most one requester is granted: its operands are steered onto alu_*, the ALU
//   result comes back in the same cycle and is captured into that requester's
//   response register at the clock edge (1-cycle latency).
//
//   Ports
//     clk, rst_n                  clock, asynchronous active-low reset
//     reqN_valid / reqN_ready     request handshake (ready is the grant)
//     reqN_A, reqN_B              32-bit operands
//     reqN_shamt, reqN_ctrl       shift amount and ALU control code
//     respN_valid / respN_ready   response handshake
//     respN_result, respN_zero    registered ALU result and Zero flag
//     alu_A, alu_B, alu_shamt,
//     alu_ctrl                    operands driven to the shared ALU
//     alu_result, alu_zero        ALU outputs, combinational from alu_*
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_A,
    input  logic [DATA_W-1:0] req0_B,
    input  logic [4:0]        req0_shamt,
    input  logic [3:0]        req0_ctrl,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_zero,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_A,
    input  logic [DATA_W-1:0] req1_B,
    input  logic [4:0]        req1_shamt,
    input  logic [3:0]        req1_ctrl,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_zero,

    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [4:0]        alu_shamt,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    logic last_grant;
    logic elig0_p0;
    logic elig1_p0;
    logic gnt0_p0;
    logic gnt1_p0;

    // A requester may only be granted if its response slot is free or is
    // being drained this same cycle.
    assign elig0_p0 = req0_valid && (!resp0_valid || resp0_ready);
    assign elig1_p0 = req1_valid && (!resp1_valid || resp1_ready);

    // ---- Stage p0: arbitration and ALU operand steering (combinational) ----
    always_comb begin
        gnt0_p0   = 1'b0;
        gnt1_p0   = 1'b0;
        alu_A     = '0;
        alu_B     = '0;
        alu_shamt = 5'd0;
        alu_ctrl  = 4'b0000;
        if (rst_n) begin
            if (elig0_p0 && elig1_p0) begin
                // Tie: the requester that was not served last wins.
                gnt0_p0 = last_grant;
                gnt1_p0 = !last_grant;
            end else begin
                gnt0_p0 = elig0_p0;
                gnt1_p0 = elig1_p0;
            end
        end
        if (gnt0_p0) begin
            alu_A     = req0_A;
            alu_B     = req0_B;
            alu_shamt = req0_shamt;
            alu_ctrl  = req0_ctrl;
        end else if (gnt1_p0) begin
            alu_A     = req1_A;
            alu_B     = req1_B;
            alu_shamt = req1_shamt;
            alu_ctrl  = req1_ctrl;
        end
    end

    assign req0_ready = gnt0_p0;
    assign req1_ready = gnt1_p0;

    // ---- Stage p1: response registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant   <= 1'b1;
            resp0_valid  <= 1'b0;
            resp0_result <= '0;
            resp0_zero   <= 1'b0;
            resp1_valid  <= 1'b0;
            resp1_result <= '0;
            resp1_zero   <= 1'b0;
        end else begin
            if (gnt0_p0) begin
                resp0_valid  <= 1'b1;
                resp0_result <= alu_result;
                resp0_zero   <= alu_zero;
                last_grant   <= 1'b0;
            end else if (resp0_valid && resp0_ready) begin
                resp0_valid <= 1'b0;
            end

            if (gnt1_p0) begin
                resp1_valid  <= 1'b1;
                resp1_result <= alu_result;
                resp1_zero   <= alu_zero;
                last_grant   <= 1'b1;
            end else if (resp1_valid && resp1_ready) begin
                resp1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
    logic [4:0]  req0_shamt = '0, req1_shamt = '0;
    logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [31:0] resp0_result, resp1_result;
    logic        resp0_zero, resp1_zero;
    logic [31:0] alu_A, alu_B, alu_result;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard and reference state
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        m_rv0 = 1'b0, m_rv1 = 1'b0, m_last = 1'b1;
    logic [31:0] m_res0 = '0, m_res1 = '0;
    logic        m_z0 = 1'b0, m_z1 = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh, input logic [3:0] c);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0100: return a ^ b;
            4'b1100: return ~(a | b);
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1110: return b << sh;
            4'b1111: return b >> sh;
            4'b1011: return $unsigned($signed(b) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    // shared ALU stand-in
    assign alu_result = alu_ref(alu_A, alu_B, alu_shamt, alu_ctrl);
    assign alu_zero   = (alu_result == 32'd0);

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
        .req0_shamt(req0_shamt), .req0_ctrl(req0_ctrl),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
        .req1_shamt(req1_shamt), .req1_ctrl(req1_ctrl),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .alu_A(alu_A), .alu_B(alu_B), .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven (phase posedge+1).
    task automatic step();
        logic e0, e1, g0, g1;
        logic [31:0] ex;
        #1;
        e0 = req0_valid && (!m_rv0 || resp0_ready);
        e1 = req1_valid && (!m_rv1 || resp1_ready);
        g0 = 1'b0;
        g1 = 1'b0;
        if (e0 && e1) begin
            g0 = m_last;
            g1 = !m_last;
        end else begin
            g0 = e0;
            g1 = e1;
        end
        check("req0_ready", 32'(req0_ready), 32'(g0));
        check("req1_ready", 32'(req1_ready), 32'(g1));
        if (g0) begin
            q0.push_back(alu_ref(req0_A, req0_B, req0_shamt, req0_ctrl));
            check("alu_A_mux0", alu_A, req0_A);
        end else if (g1) begin
            q1.push_back(alu_ref(req1_A, req1_B, req1_shamt, req1_ctrl));
            check("alu_B_mux1", alu_B, req1_B);
        end else begin
            check("alu_idle", {alu_A[15:0], alu_B[10:0], alu_shamt}, 32'd0);
            check("alu_ctrl_idle", 32'(alu_ctrl), 32'd0);
        end
        @(posedge clk);
        #1;
        if (g0) begin
            m_rv0 = 1'b1;
            if (q0.size() > 0) begin
                ex = q0.pop_front();
                m_res0 = ex;
                m_z0 = (ex == 32'd0);
            end else check("q0_empty", 32'd0, 32'd1);
        end else if (m_rv0 && resp0_ready) m_rv0 = 1'b0;
        if (g1) begin
            m_rv1 = 1'b1;
            if (q1.size() > 0) begin
                ex = q1.pop_front();
                m_res1 = ex;
                m_z1 = (ex == 32'd0);
            end else check("q1_empty", 32'd0, 32'd1);
        end else if (m_rv1 && resp1_ready) m_rv1 = 1'b0;
        if (g0) m_last = 1'b0;
        else if (g1) m_last = 1'b1;
        check("resp0_valid", 32'(resp0_valid), 32'(m_rv0));
        check("resp1_valid", 32'(resp1_valid), 32'(m_rv1));
        check("resp0_result", resp0_result, m_res0);
        check("resp1_result", resp1_result, m_res1);
        check("resp0_zero", 32'(resp0_zero), 32'(m_z0));
        check("resp1_zero", 32'(resp1_zero), 32'(m_z1));
    endtask

    // Reset pulled low between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_ctrl = 4'b0010;
        req1_ctrl = 4'b0110;
        #1;
        check("rst_resp0_valid", 32'(resp0_valid), 32'd0);
        check("rst_resp1_valid", 32'(resp1_valid), 32'd0);
        check("rst_resp0_result", resp0_result, 32'd0);
        check("rst_resp1_result", resp1_result, 32'd0);
        check("rst_zero", {30'd0, resp1_zero, resp0_zero}, 32'd0);
        check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        q0.delete();
        q1.delete();
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_last = 1'b1;
        m_res0 = '0; m_res1 = '0; m_z0 = 1'b0; m_z1 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic set0(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
        req0_valid = v; req0_ctrl = c; req0_A = a; req0_B = b; req0_shamt = sh;
    endtask

    task automatic set1(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
        req1_valid = v; req1_ctrl = c; req1_A = a; req1_B = b; req1_shamt = sh;
    endtask

    initial begin
        logic [3:0] codes [10];
        codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0100,
                  4'b1100, 4'b0111, 4'b1110, 4'b1111, 4'b1011};

        @(posedge clk);
        #1;
        do_reset();

        // single ADD on requester 0
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        set0(1'b1, 4'b0010, 32'd5, 32'd3, 5'd0);
        step();
        check("add_5_3", resp0_result, 32'd8);
        set0(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        step();

        // tie after reset: req0 first, then req1
        do_reset();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        set0(1'b1, 4'b0110, 32'd7, 32'd7, 5'd0);
        set1(1'b1, 4'b0111, 32'hFFFFFFFF, 32'd2, 5'd0);
        step();
        check("tie_first_sub", {resp0_result[30:0], resp0_zero}, 32'd1);
        step();
        check("tie_second_slt", {resp1_result[30:0], resp1_zero}, 32'd2);

        // continuous contention with random ops: alternation
        for (int i = 0; i < 8; i++) begin
            set0(1'b1, codes[$urandom_range(0, 9)], $urandom, $urandom, 5'($urandom));
            set1(1'b1, codes[$urandom_range(0, 9)], $urandom, $urandom, 5'($urandom));
            step();
        end
        set0(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        set1(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        step();

        // req0 blocked by an unconsumed response; req1 served every cycle
        resp0_ready = 1'b0;
        set0(1'b1, 4'b0010, 32'd5, 32'd3, 5'd0);
        step();
        set1(1'b1, 4'b1110, 32'd0, 32'd1, 5'd31);
        for (int i = 0; i < 4; i++) begin
            req0_A = $urandom;   // must not disturb held response
            step();
        end
        check("sll_31", resp1_result, 32'h80000000);
        check("held_8", resp0_result, 32'd8);
        set1(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);

        // consume and regrant on the same requester
        resp0_ready = 1'b1;
        set0(1'b1, 4'b1011, 32'd0, 32'hF0000000, 5'd4);
        step();
        check("sra_4", resp0_result, 32'hFF000000);
        set0(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        step();

        // reset while resp1 holds a result, then tie favours req0
        resp1_ready = 1'b0;
        set1(1'b1, 4'b0001, 32'h0F, 32'hF0, 5'd0);
        step();
        do_reset();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        set0(1'b1, 4'b0100, 32'hAA, 32'hFF, 5'd0);
        set1(1'b1, 4'b1100, 32'd0, 32'd0, 5'd0);
        step();
        step();

        // random traffic with random back-pressure
        for (int i = 0; i < 60; i++) begin
            set0(1'($urandom), codes[$urandom_range(0, 9)], $urandom, $urandom, 5'($urandom));
            set1(1'($urandom), codes[$urandom_range(0, 9)], $urandom, $urandom, 5'($urandom));
            resp0_ready = 1'($urandom);
            resp1_ready = 1'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
